// File: rtl/buffer_nport.sv
// buffer_nport: multi-port feature buffer, NUM_WR writers and NUM_RD readers share one simple-dual-port RAM.
// Latency: read accepted in cycle R returns registered data in cycle R+RAM_LATENCY+2; write commits at end of T+1.
// Backpressure: wr_ready/rd_ready are combinational round-robin grants (one-hot or zero), never dependent on ready.
//
// Build option: define BUFFER_NPORT_FIXED_PRIO_EN for fixed lowest-index-wins arbitration instead of round-robin.
//
// Ports:
//   clk, rst                 single clock, asynchronous active-high reset
//   wr_valid/wr_ready        per-port write handshake; wr_addr/wr_data packed, port i at slice i
//   rd_valid/rd_ready        per-port read handshake; rd_addr packed, port i at slice i
//   rd_data_valid/rd_data    per-port registered read return; non-returning ports output zero

// Arbiter shared by the read and write sides. gnt is forced to zero while rst is high.
module buffer_nport_arb #(
  parameter int N  = 2,
  parameter int IW = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [N-1:0]  req,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] gnt_idx,
  output logic          gnt_any
);

`ifdef BUFFER_NPORT_FIXED_PRIO_EN
  // No pointer state in this build; the clock is only wired through.
  logic unused_clk;
  assign unused_clk = clk;

  always_comb begin
    gnt_any = 1'b0;
    gnt_idx = '0;
    // Scan downward so the lowest requesting index is the last (winning) assignment.
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i]) begin
        gnt_any = 1'b1;
        gnt_idx = IW'(i);
      end
    end
    if (rst) gnt_any = 1'b0;
  end
`else
  logic [IW-1:0] ptr;
  int            cand;

  // Search order is ptr+1, ptr+2, ... wrapping modulo N. Scanning the offsets
  // from farthest to nearest leaves the nearest requester as the final winner.
  always_comb begin
    gnt_any = 1'b0;
    gnt_idx = '0;
    cand    = 0;
    for (int k = N; k >= 1; k--) begin
      cand = int'(ptr) + k;
      if (cand >= N) cand = cand - N;
      if (req[IW'(cand)]) begin
        gnt_any = 1'b1;
        gnt_idx = IW'(cand);
      end
    end
    if (rst) gnt_any = 1'b0;
  end

  // Pointer holds the last granted index; reset to N-1 so port 0 wins first.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr <= IW'(N - 1);
    end else if (gnt_any) begin
      ptr <= gnt_idx;
    end
  end
`endif

  assign gnt = gnt_any ? (N'(1) << gnt_idx) : '0;

endmodule

module buffer_nport #(
  parameter int    BUFFER_ADDR_WIDTH  = 11,
  parameter int    BUFFER_DATA_WIDTH  = 512,
  parameter int    NUM_RD             = 3,
  parameter int    NUM_WR             = 2,
  parameter int    RAM_LATENCY        = 2,
  parameter string MEM_POOL_PRIMITIVE = "auto"
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic [NUM_WR-1:0]                      wr_valid,
  output logic [NUM_WR-1:0]                      wr_ready,
  input  logic [NUM_WR*BUFFER_ADDR_WIDTH-1:0]    wr_addr,
  input  logic [NUM_WR*BUFFER_DATA_WIDTH-1:0]    wr_data,
  input  logic [NUM_RD-1:0]                      rd_valid,
  output logic [NUM_RD-1:0]                      rd_ready,
  input  logic [NUM_RD*BUFFER_ADDR_WIDTH-1:0]    rd_addr,
  output logic [NUM_RD-1:0]                      rd_data_valid,
  output logic [NUM_RD*BUFFER_DATA_WIDTH-1:0]    rd_data
);

  localparam int AW    = BUFFER_ADDR_WIDTH;
  localparam int DW    = BUFFER_DATA_WIDTH;
  localparam int DEPTH = 2 ** AW;
  localparam int WIW   = (NUM_WR > 1) ? $clog2(NUM_WR) : 1;
  localparam int RIW   = (NUM_RD > 1) ? $clog2(NUM_RD) : 1;

  // ---------------------------------------------------------------- arbiters
  logic [WIW-1:0] wr_idx;
  logic           wr_go;
  logic [RIW-1:0] rd_idx;
  logic           rd_go;

  buffer_nport_arb #(.N(NUM_WR), .IW(WIW)) u_wr_arb (
    .clk     (clk),
    .rst     (rst),
    .req     (wr_valid),
    .gnt     (wr_ready),
    .gnt_idx (wr_idx),
    .gnt_any (wr_go)
  );

  buffer_nport_arb #(.N(NUM_RD), .IW(RIW)) u_rd_arb (
    .clk     (clk),
    .rst     (rst),
    .req     (rd_valid),
    .gnt     (rd_ready),
    .gnt_idx (rd_idx),
    .gnt_any (rd_go)
  );

  // ---------------------------------------------------------- stage registers
  // Idle cycles load zeros so nothing stale lingers in the stage.
  logic           wr_en_q;
  logic [AW-1:0]  wr_addr_q;
  logic [DW-1:0]  wr_data_q;
  logic           rd_en_q;
  logic [AW-1:0]  rd_addr_q;
  logic [RIW-1:0] rd_tag_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      rd_en_q   <= 1'b0;
      rd_addr_q <= '0;
      rd_tag_q  <= '0;
    end else begin
      wr_en_q   <= wr_go;
      wr_addr_q <= wr_go ? wr_addr[AW*wr_idx +: AW] : '0;
      wr_data_q <= wr_go ? wr_data[DW*wr_idx +: DW] : '0;
      rd_en_q   <= rd_go;
      rd_addr_q <= rd_go ? rd_addr[AW*rd_idx +: AW] : '0;
      rd_tag_q  <= rd_go ? rd_idx : '0;
    end
  end

  // ---------------------------------------------------------------- RAM array
  // Write on port A, read on port B. Both happen on the same edge, and the
  // non-blocking write makes a same-address read return the old word.
  logic [DW-1:0] mem_rd;

  if (MEM_POOL_PRIMITIVE == "ultra") begin : g_uram
    (* ram_style = "ultra" *) logic [DW-1:0] mem [DEPTH];
    always_ff @(posedge clk) begin
      if (wr_en_q) mem[wr_addr_q] <= wr_data_q;
    end
    assign mem_rd = mem[rd_addr_q];
  end else if (MEM_POOL_PRIMITIVE == "b") begin : g_bram
    (* ram_style = "block" *) logic [DW-1:0] mem [DEPTH];
    always_ff @(posedge clk) begin
      if (wr_en_q) mem[wr_addr_q] <= wr_data_q;
    end
    assign mem_rd = mem[rd_addr_q];
  end else if (MEM_POOL_PRIMITIVE == "d") begin : g_dram
    (* ram_style = "distributed" *) logic [DW-1:0] mem [DEPTH];
    always_ff @(posedge clk) begin
      if (wr_en_q) mem[wr_addr_q] <= wr_data_q;
    end
    assign mem_rd = mem[rd_addr_q];
  end else begin : g_auto
    logic [DW-1:0] mem [DEPTH];
    always_ff @(posedge clk) begin
      if (wr_en_q) mem[wr_addr_q] <= wr_data_q;
    end
    assign mem_rd = mem[rd_addr_q];
  end

  // RAM read pipeline, RAM_LATENCY registers deep. Left unreset like a real
  // memory output register; the tag chain decides whether its word is used.
  logic [DW-1:0] ram_q [RAM_LATENCY];

  always_ff @(posedge clk) begin
    if (rd_en_q) ram_q[0] <= mem_rd;
    for (int i = 1; i < RAM_LATENCY; i++) begin
      ram_q[i] <= ram_q[i-1];
    end
  end

  // Tag chain tracks which requester owns each word in the RAM pipeline.
  logic [RAM_LATENCY-1:0] tag_vld;
  logic [RIW-1:0]         tag_idx [RAM_LATENCY];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tag_vld <= '0;
      for (int i = 0; i < RAM_LATENCY; i++) begin
        tag_idx[i] <= '0;
      end
    end else begin
      tag_vld[0] <= rd_en_q;
      tag_idx[0] <= rd_tag_q;
      for (int i = 1; i < RAM_LATENCY; i++) begin
        tag_vld[i] <= tag_vld[i-1];
        tag_idx[i] <= tag_idx[i-1];
      end
    end
  end

  // ------------------------------------------------------------- output stage
  logic [NUM_RD-1:0] ret_sel;

  assign ret_sel = tag_vld[RAM_LATENCY-1] ? (NUM_RD'(1) << tag_idx[RAM_LATENCY-1]) : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_data_valid <= '0;
      rd_data       <= '0;
    end else begin
      rd_data_valid <= ret_sel;
      for (int p = 0; p < NUM_RD; p++) begin
        rd_data[p*DW +: DW] <= ret_sel[p] ? ram_q[RAM_LATENCY-1] : '0;
      end
    end
  end

endmodule

// File: tb/tb_buffer_nport.sv
// Testbench for buffer_nport: default geometry DUT driven through directed steps
// with a scoreboard of expected returns, plus two small DUTs for RAM_LATENCY 1/3 and 4 writers.
module tb_buffer_nport;

  localparam int AW  = 11;
  localparam int DW  = 512;
  localparam int NRD = 3;
  localparam int NWR = 2;
  localparam int LAT = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // main DUT
  logic [NWR-1:0]    wr_valid, wr_ready;
  logic [NWR*AW-1:0] wr_addr;
  logic [NWR*DW-1:0] wr_data;
  logic [NRD-1:0]    rd_valid, rd_ready, rd_data_valid;
  logic [NRD*AW-1:0] rd_addr;
  logic [NRD*DW-1:0] rd_data;

  buffer_nport #(
    .BUFFER_ADDR_WIDTH (AW), .BUFFER_DATA_WIDTH (DW), .NUM_RD (NRD), .NUM_WR (NWR),
    .RAM_LATENCY (LAT), .MEM_POOL_PRIMITIVE ("auto")
  ) dut (
    .clk (clk), .rst (rst),
    .wr_valid (wr_valid), .wr_ready (wr_ready), .wr_addr (wr_addr), .wr_data (wr_data),
    .rd_valid (rd_valid), .rd_ready (rd_ready), .rd_addr (rd_addr),
    .rd_data_valid (rd_data_valid), .rd_data (rd_data)
  );

  // sweep DUTs: 8-bit address, 32-bit data, 2 readers, 4 writers
  logic [3:0]  s_wr_valid;
  logic [31:0] s_wr_addr;
  logic [127:0] s_wr_data;
  logic [1:0]  s_rd_valid;
  logic [15:0] s_rd_addr;
  logic [3:0]  b_wr_ready, c_wr_ready;
  logic [1:0]  b_rd_ready, c_rd_ready, b_vld, c_vld;
  logic [63:0] b_dat, c_dat;

  buffer_nport #(
    .BUFFER_ADDR_WIDTH (8), .BUFFER_DATA_WIDTH (32), .NUM_RD (2), .NUM_WR (4),
    .RAM_LATENCY (1), .MEM_POOL_PRIMITIVE ("b")
  ) dut_l1 (
    .clk (clk), .rst (rst),
    .wr_valid (s_wr_valid), .wr_ready (b_wr_ready), .wr_addr (s_wr_addr), .wr_data (s_wr_data),
    .rd_valid (s_rd_valid), .rd_ready (b_rd_ready), .rd_addr (s_rd_addr),
    .rd_data_valid (b_vld), .rd_data (b_dat)
  );

  buffer_nport #(
    .BUFFER_ADDR_WIDTH (8), .BUFFER_DATA_WIDTH (32), .NUM_RD (2), .NUM_WR (4),
    .RAM_LATENCY (3), .MEM_POOL_PRIMITIVE ("ultra")
  ) dut_l3 (
    .clk (clk), .rst (rst),
    .wr_valid (s_wr_valid), .wr_ready (c_wr_ready), .wr_addr (s_wr_addr), .wr_data (s_wr_data),
    .rd_valid (s_rd_valid), .rd_ready (c_rd_ready), .rd_addr (s_rd_addr),
    .rd_data_valid (c_vld), .rd_data (c_dat)
  );

  // ------------------------------------------------------------ bookkeeping
  int nchk  = 0;
  int nfail = 0;

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  typedef struct {
    int            port;
    logic [DW-1:0] data;
    int            due;
  } exp_t;

  exp_t sbq[$];

  // Reference memory: a read accepted in cycle R sees writes accepted up to R-1.
  logic [DW-1:0] mdl [logic [AW-1:0]];
  logic          pend_vld = 1'b0;
  logic [AW-1:0] pend_addr;
  logic [DW-1:0] pend_data;
  logic [NRD-1:0] rd_gnt_seen;

  function automatic logic [DW-1:0] mdl_rd(input logic [AW-1:0] a);
    return mdl.exists(a) ? mdl[a] : '0;
  endfunction

  function automatic logic [DW-1:0] pat(input int a);
    return {16{32'hC0DE0000 | 32'(a)}};
  endfunction

  // One clock cycle of the main DUT: sample handshakes mid-cycle, update the
  // model and scoreboard, then move to just after the next rising edge.
  task automatic step();
    exp_t e;
    @(negedge clk);
    if (pend_vld) begin
      mdl[pend_addr] = pend_data;
      pend_vld = 1'b0;
    end
    rd_gnt_seen = rd_ready;
    for (int p = 0; p < NRD; p++) begin
      if (rd_valid[p] && rd_ready[p]) begin
        e.port = p;
        e.data = mdl_rd(rd_addr[p*AW +: AW]);
        e.due  = cyc + LAT + 2;
        sbq.push_back(e);
      end
    end
    for (int p = 0; p < NWR; p++) begin
      if (wr_valid[p] && wr_ready[p]) begin
        pend_vld  = 1'b1;
        pend_addr = wr_addr[p*AW +: AW];
        pend_data = wr_data[p*DW +: DW];
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) step();
  endtask

  // ---------------------------------------------------------------- monitor
  exp_t mon_e;
  int   run    = 0;
  int   maxrun = 0;

  always @(negedge clk) begin
    if (!rst) begin
      for (int p = 0; p < NRD; p++) begin
        if (rd_data_valid[p]) begin
          if (sbq.size() == 0) begin
            chk("spurious_rd_data_valid", DW'(rd_data_valid[p]), '0);
          end else begin
            mon_e = sbq.pop_front();
            chk("ret_port", DW'(p), DW'(mon_e.port));
            chk("ret_data", rd_data[p*DW +: DW], mon_e.data);
            chk("ret_cycle", DW'(cyc), DW'(mon_e.due));
          end
        end else begin
          chk("idle_port_data_zero", rd_data[p*DW +: DW], '0);
        end
      end
      if (rd_data_valid[1]) begin
        run = run + 1;
      end else begin
        if (run > maxrun) maxrun = run;
        run = 0;
      end
    end
  end

  // --------------------------------------------------------------- stimulus
  int          acc;
  int          lat_b, lat_c;
  logic [31:0] dat_b, dat_c;
  logic [NRD-1:0] fexp;
  logic [3:0]  wexp;

  initial begin
    wr_valid = '0; wr_addr = '0; wr_data = '0; rd_valid = '0; rd_addr = '0;
    s_wr_valid = '0; s_wr_addr = '0; s_wr_data = '0; s_rd_valid = '0; s_rd_addr = '0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // reset state, with every request raised
    rd_valid = '1; wr_valid = '1; s_wr_valid = '1; s_rd_valid = '1;
    #1;
    chk("reset_rd_ready", DW'(rd_ready), '0);
    chk("reset_wr_ready", DW'(wr_ready), '0);
    chk("reset_rd_data_valid", DW'(rd_data_valid), '0);
    chk("reset_rd_data", rd_data[DW-1:0], '0);
    chk("reset_sweep_wr_ready", DW'(b_wr_ready | c_wr_ready), '0);
    rd_valid = '0; wr_valid = '0; s_wr_valid = '0; s_rd_valid = '0;
    @(posedge clk);
    #1;
    rst = 1'b0;

    // preload 0x000..0x0FF through writer 0
    for (int a = 0; a < 256; a++) begin
      wr_valid = 2'b01;
      wr_addr[0 +: AW] = AW'(a);
      wr_data[0 +: DW] = pat(a);
      step();
    end
    wr_valid = '0;
    idle(2);

    // single write on writer 1, read two cycles later on reader 2
    wr_valid = 2'b10;
    wr_addr[AW +: AW] = 11'h005;
    wr_data[DW +: DW] = {64{8'hA5}};
    step();
    wr_valid = '0;
    step();
    rd_valid = 3'b100;
    rd_addr[2*AW +: AW] = 11'h005;
    step();
    rd_valid = '0;
    idle(8);
    chk("single_rw_drained", DW'(sbq.size()), '0);

    // read/write collision on 0x010: old 0x11, new 0x22
    wr_valid = 2'b01;
    wr_addr[0 +: AW] = 11'h010;
    wr_data[0 +: DW] = DW'(8'h11);
    step();
    wr_data[0 +: DW] = DW'(8'h22);
    rd_valid = 3'b001;
    rd_addr[0 +: AW] = 11'h010;
    step();
    wr_valid = '0;
    step();
    rd_valid = '0;
    idle(8);
    chk("collision_drained", DW'(sbq.size()), '0);

    // reset with three reads in flight and a write sitting in the stage register
    rd_valid = 3'b001;
    rd_addr[0 +: AW] = 11'h001;
    step();
    rd_addr[0 +: AW] = 11'h002;
    step();
    rd_addr[0 +: AW] = 11'h003;
    wr_valid = 2'b10;
    wr_addr[AW +: AW] = 11'h020;
    wr_data[DW +: DW] = DW'(32'hDEAD);
    step();
    rst = 1'b1;
    rd_valid = '0; wr_valid = '0;
    sbq.delete();
    pend_vld = 1'b0;
    #1;
    chk("midrst_rd_data_valid", DW'(rd_data_valid), '0);
    chk("midrst_rd_data", rd_data[DW-1:0], '0);
    rd_valid = '1;
    #1;
    chk("midrst_rd_ready", DW'(rd_ready), '0);
    rd_valid = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      chk("post_reset_no_valid", DW'(rd_data_valid), '0);
      @(posedge clk);
      #1;
    end

    // fairness: all readers request for 9 cycles (0x020 still holds its old word)
    rd_valid = 3'b111;
    for (int p = 0; p < NRD; p++) rd_addr[p*AW +: AW] = 11'h020;
    for (int k = 0; k < 9; k++) begin
      step();
`ifdef BUFFER_NPORT_FIXED_PRIO_EN
      fexp = 3'b001;
`else
      fexp = 3'b001 << (k % 3);
`endif
      chk("fair_grant", DW'(rd_gnt_seen), DW'(fexp));
    end
    rd_valid = '0;
    idle(8);
    chk("fairness_drained", DW'(sbq.size()), '0);

    // streaming read of 0x000..0x0FF on reader 1
    run = 0;
    maxrun = 0;
    rd_valid = 3'b010;
    for (int a = 0; a < 256; a++) begin
      rd_addr[AW +: AW] = AW'(a);
      step();
    end
    rd_valid = '0;
    idle(8);
    chk("stream_valid_run", DW'(maxrun), DW'(256));
    chk("stream_drained", DW'(sbq.size()), '0);

    // parameter sweep: four writers in contention, then latency at RAM_LATENCY 1 and 3
    s_wr_valid = 4'hF;
    for (int i = 0; i < 4; i++) begin
      s_wr_addr[i*8 +: 8]  = 8'(i);
      s_wr_data[i*32 +: 32] = 32'hB0 + 32'(i);
    end
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
`ifdef BUFFER_NPORT_FIXED_PRIO_EN
      wexp = 4'b0001;
`else
      wexp = 4'b0001 << (k % 4);
`endif
      chk("sweep_l1_wr_grant", DW'(b_wr_ready), DW'(wexp));
      chk("sweep_l3_wr_grant", DW'(c_wr_ready), DW'(wexp));
      @(posedge clk);
      #1;
    end
    s_wr_valid = '0;
    repeat (3) @(posedge clk);
    #1;
    s_rd_valid = 2'b01;
    s_rd_addr[7:0] = 8'h00;
    @(negedge clk);
    chk("sweep_l1_rd_grant", DW'(b_rd_ready), DW'(2'b01));
    chk("sweep_l3_rd_grant", DW'(c_rd_ready), DW'(2'b01));
    acc = cyc;
    @(posedge clk);
    #1;
    s_rd_valid = '0;
    lat_b = -1; lat_c = -1; dat_b = '0; dat_c = '0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (b_vld[0] && lat_b < 0) begin
        lat_b = cyc - acc;
        dat_b = b_dat[31:0];
      end
      if (c_vld[0] && lat_c < 0) begin
        lat_c = cyc - acc;
        dat_c = c_dat[31:0];
      end
      @(posedge clk);
      #1;
    end
    chk("sweep_l1_latency", DW'(lat_b), DW'(3));
    chk("sweep_l3_latency", DW'(lat_c), DW'(5));
    chk("sweep_l1_data", DW'(dat_b), DW'(32'hB0));
    chk("sweep_l3_data", DW'(dat_c), DW'(32'hB0));

    $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
    $finish;
  end

endmodule

// File: doc/buffer_nport.md
# buffer_nport

Parametrised multi-port on-chip feature buffer for the GNN accelerator. It is the successor of the fixed three-reader/two-writer bank buffer. It generalises the reader and writer counts, the RAM latency and the geometry, and replaces fixed priority with fair round-robin arbitration. Agg, MM, save and load engines each connect through a valid/ready request port. Every requester receives its own registered read-data return.

## Interface
- BUFFER_ADDR_WIDTH, 11, word address width; depth = 2**BUFFER_ADDR_WIDTH
- BUFFER_DATA_WIDTH, 512, word width in bits
- NUM_RD, 3, number of read requester ports (1..8)
- NUM_WR, 2, number of write requester ports (1..8)
- RAM_LATENCY, 2, xpm_memory_sdpram READ_LATENCY_B (1..3)
- MEM_POOL_PRIMITIVE, "auto", "ultra"/"b"/"d"/"auto"
- clk  in  1  single clock, all logic posedge
- rst  in  1  asynchronous, active-high reset
- wr_valid  in  NUM_WR  write request per port
- wr_ready  out  NUM_WR  write grant, combinational, one-hot or zero
- wr_addr  in  NUM_WR*BUFFER_ADDR_WIDTH  packed, port i at slice i
- wr_data  in  NUM_WR*BUFFER_DATA_WIDTH  packed
- rd_valid  in  NUM_RD  read request per port
- rd_ready  out  NUM_RD  read grant, combinational, one-hot or zero
- rd_addr  in  NUM_RD*BUFFER_ADDR_WIDTH  packed
- rd_data_valid  out  NUM_RD  registered return strobe per port
- rd_data  out  NUM_RD*BUFFER_DATA_WIDTH  registered return data per port

## Operation
- One simple-dual-port RAM. Port A is write, port B is read, mode read_first, common clock, no ECC.
- Write arbiter: among asserted wr_valid, grant exactly one port per cycle. A transfer occurs when wr_valid&wr_ready. The winner's addr/data are captured into the write stage register; the RAM is written on the next edge.
- Read arbiter: same scheme, independent of the write arbiter. The winner's addr and port index (the tag) are captured into the read stage register, with enb=1.
- Round-robin: each arbiter keeps a pointer to the last granted index. The search starts at pointer+1 and wraps modulo NUM. The pointer updates only on a grant. Reset value is NUM-1, so port 0 wins first.
- The tag travels through a shift chain RAM_LATENCY deep, alongside the RAM read pipeline.
- Output stage: the tagged port gets rd_data_valid=1 and rd_data=RAM doutb. All other ports get valid=0 and data=0, with no stale data held.
- Idle cycles (no grant): stage registers load enable=0, addr=0, data=0.
- No grant is issued to a port whose valid is low. ready never depends on ready.

## Timing
- Reset values: wr_ready=0, rd_ready=0 while rst is high. rd_data_valid=0, rd_data=0, pointers=NUM-1, all stage/tag registers=0.
- Read latency: a request accepted in cycle R returns with rd_data_valid high in cycle R+RAM_LATENCY+2. The default gives 4 cycles.
- Throughput: 1 read and 1 write per cycle sustained. Back-to-back grants to the same port are allowed when it is the only requester.
- Write visibility: a write accepted in cycle T commits at the end of T+1. A read accepted in cycle T to the same address returns OLD data (read_first collision). A read accepted in T+1 or later returns NEW data.
- Simultaneous requests on all ports: each port is granted once every NUM cycles. Worst-case wait is NUM-1 cycles.
- Reset mid-operation: in-flight reads are discarded and no rd_data_valid is issued after rst deasserts. Pending writes in the stage register are dropped.
- Address wrap: addresses are unsigned, full range, no bounds check.

## Configuration
- BUFFER_NPORT_FIXED_PRIO_EN defined: both arbiters use fixed priority, lowest index wins. Pointers are not implemented. Latency and all other behaviour are unchanged.
- Undefined (default): round-robin as above.

## Test plan
- Reset: assert rst mid-burst with 3 reads in flight. Require all outputs 0, no rd_data_valid for 6 cycles after release, and the first grant to port 0.
- Single write then read: write addr 0x005 data 0xA5..A5 via wr port 1. Read the same address via rd port 2 two cycles later. Require rd_data_valid[2] exactly 4 cycles after acceptance with data 0xA5..A5, and ports 0/1 output 0.
- Collision: the same-cycle read and write to 0x010 (old 0x11, new 0x22) must return 0x11. A read one cycle later must return 0x22.
- Fairness: all NUM_RD=3 ports request continuously for 9 cycles. Require grants 0,1,2,0,1,2,0,1,2 (fixed-prio build: 0 all 9 cycles).
- Streaming: one port reads 0x000..0x0FF back-to-back. Require 256 consecutive valid cycles with data matching the preloaded contents in order.
- Parameter sweep: RAM_LATENCY=1 and 3, NUM_WR=4. Require read latency 3 and 5 cycles, and round-robin across 4 writers.
